// File: rtl/ssd_display_driver.sv
// ssd_display_driver: converts a 13-bit binary value to four BCD digits with an
// iterative shift-add-3 engine and multiplexes them onto a common-anode 4-digit
// seven-segment display (active-low anodes and segments).
// Optional feature macro: SSD_LEADING_ZERO_BLANK_EN (blank leading zero digits).
module ssd_display_driver #(
    parameter int REFRESH_BITS = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    output logic [3:0]  anode,
    output logic [6:0]  segments,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;

    // Nibble correction applied before each shift so the nibble stays decimal.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            add3 = nib + 4'd3;
        end else begin
            add3 = nib;
        end
    endfunction

    // BCD digit to active-low {g,f,e,d,c,b,a}; non-decimal codes are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [1:0]              state_q,    state_d;
    logic [12:0]             bin_q,      bin_d;
    logic [15:0]             bcd_q,      bcd_d;
    logic [3:0]              count_q,    count_d;
    logic [15:0]             digits_q,   digits_d;
    logic                    busy_q,     busy_d;
    logic [REFRESH_BITS-1:0] refresh_q,  refresh_d;
    logic [3:0]              anode_q,    anode_d;
    logic [6:0]              segments_q, segments_d;

    logic [15:0] bcd_adj_s;
    logic [1:0]  digit_idx_s;
    logic [3:0]  cur_digit_s;
    logic        blank_s;

    // Conversion FSM: capture, 13 adjust-and-shift steps, atomic digit load.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        count_d   = count_q;
        digits_d  = digits_q;
        bcd_adj_s = {add3(bcd_q[15:12]), add3(bcd_q[11:8]),
                     add3(bcd_q[7:4]),   add3(bcd_q[3:0])};
        case (state_q)
            IDLE: begin
                bin_d   = value;
                bcd_d   = 16'd0;
                count_d = 4'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d   = (bcd_adj_s << 1) | {15'd0, bin_q[12]};
                bin_d   = bin_q << 1;
                count_d = count_q + 4'd1;
                if (count_q == 4'd12) begin
                    state_d = LOAD;
                end else begin
                    state_d = SHIFT;
                end
            end
            LOAD: begin
                digits_d = bcd_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Display scan: free-running refresh counter selects the digit slot.
    always_comb begin
        refresh_d   = refresh_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
        digit_idx_s = refresh_q[REFRESH_BITS-1 -: 2];
        case (digit_idx_s)
            2'd0: begin
                anode_d     = 4'b1110;
                cur_digit_s = digits_q[3:0];
            end
            2'd1: begin
                anode_d     = 4'b1101;
                cur_digit_s = digits_q[7:4];
            end
            2'd2: begin
                anode_d     = 4'b1011;
                cur_digit_s = digits_q[11:8];
            end
            2'd3: begin
                anode_d     = 4'b0111;
                cur_digit_s = digits_q[15:12];
            end
            default: begin
                anode_d     = 4'b1111;
                cur_digit_s = 4'd0;
            end
        endcase
`ifdef SSD_LEADING_ZERO_BLANK_EN
        // A slot is blank when it and every higher digit is zero; ones never blanks.
        case (digit_idx_s)
            2'd1:    blank_s = (digits_q[15:4] == 12'd0);
            2'd2:    blank_s = (digits_q[15:8] == 8'd0);
            2'd3:    blank_s = (digits_q[15:12] == 4'd0);
            default: blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
        if (blank_s) begin
            anode_d    = 4'b1111;
            segments_d = 7'b1111111;
        end else begin
            segments_d = seg_decode(cur_digit_s);
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= 13'd0;
            bcd_q      <= 16'd0;
            count_q    <= 4'd0;
            digits_q   <= 16'd0;
            busy_q     <= 1'b0;
            refresh_q  <= {REFRESH_BITS{1'b0}};
            anode_q    <= 4'b1111;
            segments_q <= 7'b1111111;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            count_q    <= count_d;
            digits_q   <= digits_d;
            busy_q     <= busy_d;
            refresh_q  <= refresh_d;
            anode_q    <= anode_d;
            segments_q <= segments_d;
        end
    end

    assign anode    = anode_q;
    assign segments = segments_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Scoreboard bench for ssd_display_driver (REFRESH_BITS = 4). The stimulus side
// keeps a cycle model (refresh counter, conversion phase, displayed digits) and
// pushes the expected {busy, anode, segments} after every clock edge; a monitor
// pops and compares on the falling edge.
module tb_ssd_display_driver;

    localparam int RB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] value;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        busy;

    always #5 clk = ~clk;

    ssd_display_driver #(.REFRESH_BITS(RB)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .anode    (anode),
        .segments (segments),
        .busy     (busy)
    );

    logic [11:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int          mcnt;
    int          mp;
    logic [12:0] mcap;
    int          mdig[4];
    int          cyc = 0;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       seg_of = 7'b1000000;
            1:       seg_of = 7'b1111001;
            2:       seg_of = 7'b0100100;
            3:       seg_of = 7'b0110000;
            4:       seg_of = 7'b0011001;
            5:       seg_of = 7'b0010010;
            6:       seg_of = 7'b0000010;
            7:       seg_of = 7'b1111000;
            8:       seg_of = 7'b0000000;
            9:       seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    task automatic step();
        int          idx;
        logic [3:0]  an;
        logic [6:0]  sg;
        logic [3:0]  one;
        logic        blank;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            mcnt = 0;
            mp   = 0;
            for (int i = 0; i < 4; i++) mdig[i] = 0;
            exp_q.push_back({1'b0, 4'b1111, 7'b1111111});
        end else begin
            idx = (mcnt >> 2) & 3;
            one = 4'b0001;
            an  = ~(one << idx);
            sg  = seg_of(mdig[idx]);
            blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
            if (idx != 0) begin
                blank = 1'b1;
                for (int i = idx; i < 4; i++) if (mdig[i] != 0) blank = 1'b0;
            end
`endif
            if (blank) begin
                an = 4'b1111;
                sg = 7'b1111111;
            end
            if (mp == 0) mcap = value;
            if (mp == 14) begin
                mdig[0] = int'(mcap) % 10;
                mdig[1] = (int'(mcap) / 10) % 10;
                mdig[2] = (int'(mcap) / 100) % 10;
                mdig[3] = (int'(mcap) / 1000) % 10;
            end
            mp   = (mp == 14) ? 0 : mp + 1;
            mcnt = (mcnt + 1) % (1 << RB);
            exp_q.push_back({(mp != 0), an, sg});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        logic [11:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({busy, anode, segments} !== e) begin
                n_errors++;
                $display("FAIL outputs cyc=%0d value=%0d: got busy=%b anode=%b seg=%b, want busy=%b anode=%b seg=%b",
                         cyc, value, busy, anode, segments, e[11], e[10:7], e[6:0]);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        value = 13'd0;
        mcnt  = 0;
        mp    = 0;
        mcap  = 13'd0;
        for (int i = 0; i < 4; i++) mdig[i] = 0;

        // Reset held three cycles, then value 0 scanned across all slots
        run(3);
        rst = 1'b0;
        run(20);

        // Typical value
        value = 13'd1234;
        run(48);

        // Maximum value
        value = 13'd8191;
        run(48);

        // Value changed three cycles after capture must not tear the digits
        value = 13'd1234;
        for (int i = 0; i < 40 && mp != 1; i++) step();
        run(3);
        value = 13'd5;
        run(50);

        // Small value: leading-zero behaviour depends on the build
        value = 13'd7;
        run(48);

        // Reset pulse mid-conversion (shift count 6), then restart
        value = 13'd4096;
        for (int i = 0; i < 40 && mp != 7; i++) step();
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(40);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
